rom_dl_sequencer: RTL and testbench
===================================

Name: rom_dl_sequencer

Overview:
- Sequences the HPS ioctl ROM download into the core's ROM regions through a single shared memory write port.
- Decodes ioctl_addr into one of four region chip-selects plus an in-region offset, and buffers one byte with ioctl_wait back-pressure.
- Holds the game core in reset until the download has drained and a settle interval has elapsed.
- Sits between hps_io and the ROM/BRAM banks inside emu; clocked on clk_sys.

Parameters:
- R1_BASE, 16'h4000, first byte address of region 1; region 0 spans 0..R1_BASE-1.
- R2_BASE, 16'h8000, first byte address of region 2.
- R3_BASE, 16'hA000, first byte address of region 3.
- TOTAL_BYTES, 17'h0C000, first out-of-range address.
- SETTLE_CYCLES, 1024, clk_sys cycles core_reset stays high after the drain completes; must be ≥1.
- ACK_TIMEOUT, 15, maximum cycles to wait for mem_ack per byte.
- CHECKSUM, 8'h00, expected 8-bit sum; used only with DL_CHECKSUM_EN.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  high while a download is in progress.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- mem_cs  out  4  one-hot region select; valid while mem_we is high.
- mem_addr  out  16  offset within the selected region.
- mem_data  out  8  write data.
- mem_we  out  1  write request; held until mem_ack or timeout.
- mem_ack  in  1  write accepted.
- core_reset  out  1  active-high reset to the game core.
- dl_done  out  1  high in RUN.
- dl_error  out  1  sticky error flag; cleared by the start of a new download.
- byte_count  out  17  bytes accepted in the current download.
- dl_sum  out  8  running checksum.

Behaviour:
- Reset (reset_n=0 at a clock edge) forces:
  - state IDLE, buffer empty.
  - core_reset=1; ioctl_wait, mem_we, dl_done, dl_error = 0.
  - mem_cs, mem_addr, mem_data, byte_count, dl_sum = 0.
  - Reset mid-download drops the buffered byte and takes effect the same edge.
- States: IDLE, LOAD, DRAIN, SETTLE, RUN.
- Transitions:
  - IDLE→LOAD when ioctl_download=1.
  - LOAD→DRAIN when ioctl_download=0.
  - DRAIN→SETTLE when the buffer is empty.
  - SETTLE→RUN after SETTLE_CYCLES cycles.
  - Rising edge of ioctl_download in DRAIN/SETTLE/RUN → LOAD, with core_reset=1 on the next cycle.
- Entering LOAD clears byte_count, dl_sum and dl_error.
- core_reset=0 only in RUN. dl_done = (state==RUN).
- Capture (LOAD only): ioctl_wr with buffer empty and ioctl_addr < TOTAL_BYTES:
  - latch data, offset (ioctl_addr minus region base, 16 bits) and one-hot region.
  - Region select: addr < R1_BASE → 0; < R2_BASE → 1; < R3_BASE → 2; else 3.
  - mem_we=1 on the next cycle; latency 1 cycle.
  - byte_count increments on capture.
- ioctl_addr ≥ TOTAL_BYTES: byte ignored, dl_error=1, byte_count unchanged.
- ioctl_wait = buffer full. ioctl_wr while the buffer is full: byte dropped, dl_error=1.
- Write handshake:
  - mem_we, mem_cs, mem_addr, mem_data stay stable until the cycle mem_ack=1 is sampled.
  - The buffer empties that edge; mem_we=0 on the next cycle.
  - A new capture may occur in the same cycle the ack empties the buffer, giving back-to-back writes with mem_we continuously high.
- Timeout: ACK_TIMEOUT cycles with mem_we=1 and no mem_ack → drop the byte, mem_we=0, dl_error=1.
- ioctl_wr outside LOAD is ignored with no error. In DRAIN the pending write completes normally.
- The settle counter counts SETTLE_CYCLES-1 down to 0; RUN is entered on the edge after it reaches 0.
- byte_count saturates at 17'h1FFFF.

Optional Feature:
- Macro: DL_CHECKSUM_EN.
- Defined:
  - dl_sum = mod-256 sum of each byte, added on capture.
  - On DRAIN→SETTLE, dl_sum≠CHECKSUM sets dl_error=1; sequencing still proceeds to RUN.
- Undefined: dl_sum is tied to 0 and no checksum comparison is made.

Test Plan:
1. Reset low 2 cycles mid-LOAD with buffer full → next cycle IDLE, core_reset=1, mem_we=0, ioctl_wait=0, byte_count=0.
2. Download addrs 0x0000, 0x4001, 0x8002, 0xA003 with data 11/22/33/44, mem_ack 1 cycle after mem_we → mem_cs 0001/0010/0100/1000, mem_addr 0/1/2/3, byte_count=4, dl_error=0.
3. mem_ack held low 5 cycles, second ioctl_wr during that window → ioctl_wait=1 from capture to ack, second byte dropped, dl_error=1.
4. mem_ack never asserted, ACK_TIMEOUT=15 → mem_we falls after 15 cycles, dl_error=1, FSM still reaches RUN.
5. SETTLE_CYCLES=4, download ends with empty buffer → core_reset falls exactly 4 cycles after SETTLE entry; re-raising ioctl_download in RUN → core_reset=1 next cycle, byte_count cleared.
6. DL_CHECKSUM_EN, CHECKSUM=8'h10, bytes 0x08,0x08 → dl_sum=0x10, dl_error=0; bytes 0x08,0x09 → dl_error=1 on SETTLE entry.

Source files
------------

// File: rtl/rom_dl_sequencer.sv
`timescale 1ns/1ps
// rom_dl_sequencer
//   Sequences the HPS ioctl ROM download into the core ROM regions through one
//   shared memory write port. A one-byte buffer is placed between ioctl and the
//   memory port, and ioctl_wait holds hps_io off while that byte is outstanding.
//   The game core is held in reset until the download has drained and a settle
//   interval has elapsed.
//
//   Optional feature: define DL_CHECKSUM_EN to accumulate dl_sum and compare it
//   against CHECKSUM when the drain completes. Without it dl_sum reads 0.
//
// Ports
//   clk_sys        system clock, rising edge
//   reset_n        synchronous active-low reset
//   ioctl_download high while a download is in progress
//   ioctl_wr       one-cycle byte strobe
//   ioctl_addr     byte address (25 bits)
//   ioctl_dout     byte data
//   ioctl_wait     back-pressure to hps_io (buffer full)
//   mem_cs         one-hot region select, valid while mem_we is high
//   mem_addr       offset within the selected region
//   mem_data       write data
//   mem_we         write request, held until mem_ack or timeout
//   mem_ack        write accepted
//   core_reset     active-high reset to the game core (low only in RUN)
//   dl_done        high in RUN
//   dl_error       sticky error, cleared when a new download starts
//   byte_count     bytes accepted in the current download (saturating)
//   dl_sum         running mod-256 byte sum (0 unless DL_CHECKSUM_EN)
module rom_dl_sequencer #(
    parameter logic [15:0] R1_BASE       = 16'h4000,
    parameter logic [15:0] R2_BASE       = 16'h8000,
    parameter logic [15:0] R3_BASE       = 16'hA000,
    parameter logic [16:0] TOTAL_BYTES   = 17'h0C000,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned ACK_TIMEOUT   = 15,
    parameter logic [7:0]  CHECKSUM      = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [3:0]  mem_cs,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_error,
    output logic [16:0] byte_count,
    output logic [7:0]  dl_sum
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_SETTLE,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic               full_q, full_d;
    logic [3:0]         cs_q, cs_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [16:0]        count_q, count_d;
    logic               err_q, err_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               dl_prev_q, dl_prev_d;

    logic               dl_rise;
    logic               addr_ok;
    logic               buf_free;

`ifdef DL_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    function automatic logic [16:0] sat_inc(input logic [16:0] v);
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

    function automatic logic [3:0] region_cs(input logic [24:0] a);
        if (a < {9'd0, R1_BASE})      return 4'b0001;
        else if (a < {9'd0, R2_BASE}) return 4'b0010;
        else if (a < {9'd0, R3_BASE}) return 4'b0100;
        else                          return 4'b1000;
    endfunction

    function automatic logic [15:0] region_base(input logic [24:0] a);
        if (a < {9'd0, R1_BASE})      return 16'h0000;
        else if (a < {9'd0, R2_BASE}) return R1_BASE;
        else if (a < {9'd0, R3_BASE}) return R2_BASE;
        else                          return R3_BASE;
    endfunction

    assign dl_rise  = ioctl_download & ~dl_prev_q;
    assign addr_ok  = (ioctl_addr < {8'd0, TOTAL_BYTES});
    // An ack at this edge frees the buffer, so a byte arriving in the same
    // cycle can be captured and mem_we stays high back to back.
    assign buf_free = ~full_q | mem_ack;

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        cs_d      = cs_q;
        addr_d    = addr_q;
        data_d    = data_q;
        count_d   = count_q;
        err_d     = err_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        dl_prev_d = ioctl_download;
`ifdef DL_CHECKSUM_EN
        sum_d     = sum_q;
`endif

        // Memory write handshake: complete on ack, abandon on timeout.
        if (full_q) begin
            if (mem_ack) begin
                full_d = 1'b0;
            end else if (tmo_q == TMO_LAST) begin
                full_d = 1'b0;
                err_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        // Byte capture from ioctl, only while loading.
        if (state_q == ST_LOAD && ioctl_wr) begin
            if (!addr_ok || !buf_free) begin
                err_d = 1'b1;
            end else begin
                full_d  = 1'b1;
                tmo_d   = '0;
                cs_d    = region_cs(ioctl_addr);
                addr_d  = ioctl_addr[15:0] - region_base(ioctl_addr);
                data_d  = ioctl_dout;
                count_d = sat_inc(count_q);
`ifdef DL_CHECKSUM_EN
                sum_d   = sum_q + ioctl_dout;
`endif
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ioctl_download) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dl_rise) begin
                    state_d = ST_LOAD;
                end else if (!full_q) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LAST;
`ifdef DL_CHECKSUM_EN
                    if (sum_q != CHECKSUM) err_d = 1'b1;
`endif
                end
            end
            ST_SETTLE: begin
                if (dl_rise) begin
                    state_d = ST_LOAD;
                end else if (settle_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (dl_rise) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new download starts with clean statistics; this also discards an
        // error raised by a write still draining from the previous download.
        if (state_d == ST_LOAD && state_q != ST_LOAD) begin
            count_d = '0;
            err_d   = 1'b0;
`ifdef DL_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            full_q    <= 1'b0;
            cs_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            settle_q  <= '0;
            tmo_q     <= '0;
            dl_prev_q <= 1'b0;
`ifdef DL_CHECKSUM_EN
            sum_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            cs_q      <= cs_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            count_q   <= count_d;
            err_q     <= err_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            dl_prev_q <= dl_prev_d;
`ifdef DL_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign ioctl_wait = full_q;
    assign mem_we     = full_q;
    assign mem_cs     = cs_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign core_reset = (state_q != ST_RUN);
    assign dl_done    = (state_q == ST_RUN);
    assign dl_error   = err_q;
    assign byte_count = count_q;

`ifdef DL_CHECKSUM_EN
    assign dl_sum = sum_q;
`else
    logic [7:0] unused_checksum;
    assign unused_checksum = CHECKSUM;
    assign dl_sum          = 8'h00;
`endif

endmodule

// File: tb/tb_rom_dl_sequencer.sv
`timescale 1ns/1ps
module tb_rom_dl_sequencer;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 15;
    localparam logic [7:0]  CSUM   = 8'h10;
    localparam int          NEVER  = -1;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_DRAIN  = 2;
    localparam int P_SETTLE = 3;
    localparam int P_RUN    = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        mem_ack = 1'b0;
    logic        ioctl_wait;
    logic [3:0]  mem_cs;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        core_reset;
    logic        dl_done;
    logic        dl_error;
    logic [16:0] byte_count;
    logic [7:0]  dl_sum;

    always #5 clk_sys = ~clk_sys;

    rom_dl_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .ACK_TIMEOUT   (TMO),
        .CHECKSUM      (CSUM)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .mem_cs         (mem_cs),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_we         (mem_we),
        .mem_ack        (mem_ack),
        .core_reset     (core_reset),
        .dl_done        (dl_done),
        .dl_error       (dl_error),
        .byte_count     (byte_count),
        .dl_sum         (dl_sum)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the sequencer as seen from its ports.
    int          m_phase = P_IDLE;
    bit          m_full = 0;
    int          m_hi = 0;          // cycles the current write has been presented
    int          m_count = 0;
    bit          m_err = 0;
    int          m_sum = 0;
    int          m_settle_left = 0;
    bit          m_prev_dl = 0;
    logic [3:0]  m_cs = '0;
    logic [15:0] m_off = '0;
    logic [7:0]  m_data = '0;
    int          ack_delay = NEVER;

    logic [24:0] s2_addr [4] = '{25'h00000, 25'h04001, 25'h08002, 25'h0A003};
    logic [7:0]  s2_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0]  s2_cs   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void region_of(input int a, output logic [3:0] cs, output logic [15:0] off);
        if (a < 'h4000)      begin cs = 4'b0001; off = 16'(a);          end
        else if (a < 'h8000) begin cs = 4'b0010; off = 16'(a - 'h4000); end
        else if (a < 'hA000) begin cs = 4'b0100; off = 16'(a - 'h8000); end
        else                 begin cs = 4'b1000; off = 16'(a - 'hA000); end
    endfunction

    // Apply the rules to the edge that has just happened, using the inputs
    // that were stable across it.
    task automatic model_edge();
        bit rise, acked, timed_out, freed, was_full;
        int nxt;
        if (!reset_n) begin
            m_phase = P_IDLE; m_full = 0; m_hi = 0; m_count = 0; m_err = 0;
            m_sum = 0; m_prev_dl = 0; m_cs = '0; m_off = '0; m_data = '0;
            return;
        end
        was_full  = m_full;
        rise      = ioctl_download && !m_prev_dl;
        acked     = m_full && mem_ack;
        timed_out = m_full && !mem_ack && (m_hi == TMO);
        freed     = !m_full || acked;
        if (acked || timed_out) m_full = 0;
        if (timed_out) m_err = 1;
        if (m_phase == P_LOAD && ioctl_wr) begin
            if (ioctl_addr >= 25'h0C000 || !freed) begin
                m_err = 1;
            end else begin
                m_full = 1;
                m_hi   = 0;
                region_of(int'(ioctl_addr), m_cs, m_off);
                m_data = ioctl_dout;
                if (m_count < 'h1FFFF) m_count++;
                m_sum = (m_sum + int'(ioctl_dout)) % 256;
            end
        end
        nxt = m_phase;
        case (m_phase)
            P_IDLE:  if (ioctl_download) nxt = P_LOAD;
            P_LOAD:  if (!ioctl_download) nxt = P_DRAIN;
            P_DRAIN: begin
                if (rise) nxt = P_LOAD;
                else if (!was_full) begin
                    nxt = P_SETTLE;
                    m_settle_left = SETTLE;
`ifdef DL_CHECKSUM_EN
                    if (m_sum != int'(CSUM)) m_err = 1;
`endif
                end
            end
            P_SETTLE: begin
                if (rise) nxt = P_LOAD;
                else begin
                    m_settle_left--;
                    if (m_settle_left == 0) nxt = P_RUN;
                end
            end
            P_RUN:   if (rise) nxt = P_LOAD;
            default: nxt = P_IDLE;
        endcase
        if (nxt == P_LOAD && m_phase != P_LOAD) begin
            m_count = 0; m_sum = 0; m_err = 0;
        end
        m_phase   = nxt;
        m_prev_dl = ioctl_download;
    endtask

    task automatic check_outputs();
        int exp_sum;
`ifdef DL_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = 0;
`endif
        check("core_reset", core_reset, m_phase != P_RUN);
        check("dl_done",    dl_done,    m_phase == P_RUN);
        check("ioctl_wait", ioctl_wait, m_full);
        check("mem_we",     mem_we,     m_full);
        check("byte_count", byte_count, m_count);
        check("dl_error",   dl_error,   m_err);
        check("dl_sum",     dl_sum,     exp_sum);
        check("mem_cs",     mem_cs,     m_cs);
        check("mem_addr",   mem_addr,   m_off);
        check("mem_data",   mem_data,   m_data);
    endtask

    // Memory side: acknowledge once the write has been presented for more
    // than ack_delay cycles (never, for NEVER).
    task automatic respond();
        if (m_full) begin
            m_hi++;
            mem_ack = (ack_delay >= 0) && (m_hi > ack_delay);
        end else begin
            mem_ack = 1'b0;
        end
    endtask

    task automatic step(input bit rst_n, input bit dl, input bit wr,
                        input logic [24:0] addr, input logic [7:0] data);
        reset_n        = rst_n;
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = addr;
        ioctl_dout     = data;
        @(posedge clk_sys);
        #1;
        model_edge();
        check_outputs();
        respond();
    endtask

    task automatic idle(input int n, input bit dl);
        for (int i = 0; i < n; i++) step(1'b1, dl, 1'b0, '0, '0);
    endtask

    task automatic finish_dl(output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, '0, '0);
            n++;
        end while (!dl_done && n < 200);
        check("reach_run", dl_done, 1'b1);
    endtask

    function automatic logic [24:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r == 0) return 25'h0C000;
        if (r == 1) return 25'($urandom_range(32'h0C000, 32'h1FFFFFF));
        if (r < 6) begin
            case ($urandom_range(0, 6))
                0:       return 25'h03FFF;
                1:       return 25'h04000;
                2:       return 25'h07FFF;
                3:       return 25'h08000;
                4:       return 25'h09FFF;
                5:       return 25'h0A000;
                default: return 25'h0BFFF;
            endcase
        end
        return 25'($urandom_range(0, 32'h0BFFF));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;

        // Reset, then reset again mid-load with the buffer full.
        ack_delay = NEVER;
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_mem_we",     mem_we,     1'b0);
        check("rst_wait",       ioctl_wait, 1'b0);
        check("rst_dl_done",    dl_done,    1'b0);
        check("rst_dl_error",   dl_error,   1'b0);
        check("rst_byte_count", byte_count, 17'd0);
        check("rst_mem_cs",     mem_cs,     4'd0);
        check("rst_mem_addr",   mem_addr,   16'd0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 25'h00123, 8'h5A);
        check("s1_wait_full", ioctl_wait, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        check("s1_core_reset", core_reset, 1'b1);
        check("s1_mem_we",     mem_we,     1'b0);
        check("s1_wait",       ioctl_wait, 1'b0);
        check("s1_byte_count", byte_count, 17'd0);

        // One byte per region.
        ack_delay = 1;
        step(1'b1, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, s2_addr[i], s2_data[i]);
            check("s2_cs",   mem_cs,   s2_cs[i]);
            check("s2_addr", mem_addr, 16'(i));
            check("s2_data", mem_data, s2_data[i]);
            idle(3, 1'b1);
        end
        check("s2_byte_count", byte_count, 17'd4);
        check("s2_dl_error",   dl_error,   1'b0);

        // Settle length and restart from RUN.
        finish_dl(n);
        check("s5_cycles_to_run", n, 6);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        check("s5_core_reset", core_reset, 1'b1);
        check("s5_byte_count", byte_count, 17'd0);

        // Slow ack, second byte arrives while the first is pending.
        ack_delay = 5;
        step(1'b1, 1'b1, 1'b1, 25'h00010, 8'hA1);
        check("s3_wait", ioctl_wait, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 25'h00011, 8'hA2);
        check("s3_err", dl_error, 1'b1);
        idle(6, 1'b1);
        check("s3_mem_we", mem_we, 1'b0);
        check("s3_byte_count", byte_count, 17'd1);
        step(1'b1, 1'b1, 1'b1, 25'h0C000, 8'hEE);
        check("s3_oob_count", byte_count, 17'd1);
        finish_dl(n);

        // No ack at all: write abandoned after the timeout.
        ack_delay = NEVER;
        step(1'b1, 1'b1, 1'b0, '0, '0);
        check("s4_err_cleared", dl_error, 1'b0);
        step(1'b1, 1'b1, 1'b1, 25'h05000, 8'h77);
        n = 0;
        while (mem_we && n < 40) begin
            step(1'b1, 1'b1, 1'b0, '0, '0);
            n++;
        end
        check("s4_tmo_len", n, TMO);
        check("s4_err", dl_error, 1'b1);
        finish_dl(n);
        check("s4_err_in_run", dl_error, 1'b1);

        // Checksum: matching and mismatching downloads.
        ack_delay = 0;
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 25'h00100, 8'h08);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 25'h00101, 8'h08);
        idle(2, 1'b1);
        finish_dl(n);
`ifdef DL_CHECKSUM_EN
        check("s6_sum_ok", dl_sum, 8'h10);
`else
        check("s6_sum_ok", dl_sum, 8'h00);
`endif
        check("s6_err_ok", dl_error, 1'b0);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 25'h00100, 8'h08);
        step(1'b1, 1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 25'h00101, 8'h09);
        idle(2, 1'b1);
        finish_dl(n);
`ifdef DL_CHECKSUM_EN
        check("s6_err_bad", dl_error, 1'b1);
`else
        check("s6_err_bad", dl_error, 1'b0);
`endif

        // Random downloads with varying memory latency and restarts.
        for (int d = 0; d < 10; d++) begin
            case ($urandom_range(0, 5))
                0:       ack_delay = NEVER;
                1:       ack_delay = 0;
                2:       ack_delay = 2;
                3:       ack_delay = 3;
                default: ack_delay = 1;
            endcase
            step(1'b1, 1'b1, 1'b0, '0, '0);
            len = int'($urandom_range(20, 40));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 1) == 1)
                    step(1'b1, 1'b1, 1'b1, rand_addr(), 8'($urandom));
                else
                    step(1'b1, 1'b1, 1'b0, '0, '0);
            end
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 8)), 1'b0);
            else finish_dl(n);
        end
        finish_dl(n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
